// File: rtl/irq_sched_pkg.sv
// Shared constants for the interrupt scheduler: FSM encoding, register map, widths.
package irq_sched_pkg;

    localparam int unsigned IRQ_LINES = 16;
    localparam int unsigned IRQ_IDX_W = 4;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_REQ     = 2'd1;
    localparam logic [1:0] ST_SERVICE = 2'd2;

    localparam logic [1:0] REG_PEND = 2'd0;
    localparam logic [1:0] REG_EN   = 2'd1;
    localparam logic [1:0] REG_VEC  = 2'd2;
    localparam logic [1:0] REG_STAT = 2'd3;

endpackage

// File: rtl/irq_prio_enc.sv
// Lowest-index-wins priority encoder over the active (pending & enabled) lines.
module irq_prio_enc
    import irq_sched_pkg::*;
(
    input  logic [IRQ_LINES-1:0] req_i,
    output logic [IRQ_IDX_W-1:0] idx_o,
    output logic                 vld_o
);

    always_comb begin
        idx_o = '0;
        vld_o = 1'b0;
        // Scan downward so the lowest set index is the last one written.
        for (int i = IRQ_LINES - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                idx_o = i[IRQ_IDX_W-1:0];
                vld_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/irq_scheduler.sv
// Memory-mapped interrupt sequencer: edge-latched pending lines, enable mask,
// one vectored request at a time, held until CPU ack and EOI write.
module irq_scheduler
    import irq_sched_pkg::*;
#(
    parameter logic [15:0] BASE_ADDR = 16'h0420,
    parameter int unsigned VEC_SHIFT = 2
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_we,
    input  logic [15:0]          i_addr,
    input  logic [15:0]          i_data,
    output logic [15:0]          o_data,
    input  logic [IRQ_LINES-1:0] i_lines,
    output logic                 o_int,
    output logic [15:0]          o_int_addr,
    output logic [IRQ_IDX_W-1:0] o_int_num,
    input  logic                 i_ack
);

    logic [IRQ_LINES-1:0] pend_q, pend_d, en_q, en_d, prev_q;
    logic [IRQ_LINES-1:0] edges, w1c, ack_clr, active;
    logic [15:0]          vec_q, vec_d, data_q, data_d, addr_q, addr_d;
    logic [1:0]           state_q, state_d;
    logic                 int_q, int_d;
    logic [IRQ_IDX_W-1:0] num_q, num_d, sel_idx;
    logic                 sel_vld;

    logic [15:0] off;
    logic        hit, wr_pend, wr_en, wr_vec, wr_eoi;

    // Offset arithmetic keeps the decode correct for any BASE_ADDR alignment.
    assign off     = i_addr - BASE_ADDR;
    assign hit     = (off[15:2] == 14'd0);
    assign wr_pend = i_we && hit && (off[1:0] == REG_PEND);
    assign wr_en   = i_we && hit && (off[1:0] == REG_EN);
    assign wr_vec  = i_we && hit && (off[1:0] == REG_VEC);
    assign wr_eoi  = i_we && hit && (off[1:0] == REG_STAT);

    assign edges  = i_lines & ~prev_q;
    assign w1c    = wr_pend ? i_data : '0;
    assign active = pend_q & en_q;

    irq_prio_enc u_enc (
        .req_i (active),
        .idx_o (sel_idx),
        .vld_o (sel_vld)
    );

    always_comb begin
        state_d = state_q;
        int_d   = int_q;
        num_d   = num_q;
        addr_d  = addr_q;
        ack_clr = '0;
        case (state_q)
            ST_IDLE: begin
                if (sel_vld) begin
                    state_d = ST_REQ;
                    int_d   = 1'b1;
                    num_d   = sel_idx;
                    addr_d  = vec_q + (16'(sel_idx) << VEC_SHIFT);
                end
            end
            ST_REQ: begin
                // Withdraw checks registered state, so it lags the bus write by a cycle.
                if (i_ack) begin
                    ack_clr[num_q] = 1'b1;
                    int_d          = 1'b0;
                    state_d        = ST_SERVICE;
                end else if (!(pend_q[num_q] && en_q[num_q])) begin
                    int_d   = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            ST_SERVICE: begin
                if (wr_eoi) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        // A fresh edge beats a same-cycle clear.
        pend_d = (pend_q & ~(w1c | ack_clr)) | edges;
        en_d   = wr_en  ? i_data : en_q;
        vec_d  = wr_vec ? i_data : vec_q;
        data_d = '0;
        if (!i_we && hit) begin
            case (off[1:0])
                REG_PEND: data_d = pend_q;
                REG_EN:   data_d = en_q;
                REG_VEC:  data_d = vec_q;
                default:  data_d = {state_q == ST_SERVICE, state_q == ST_REQ, 10'b0, num_q};
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        prev_q <= i_lines;
        if (i_rst) begin
            pend_q  <= '0;
            en_q    <= '0;
            vec_q   <= '0;
            data_q  <= '0;
            addr_q  <= '0;
            num_q   <= '0;
            int_q   <= 1'b0;
            state_q <= ST_IDLE;
        end else begin
            pend_q  <= pend_d;
            en_q    <= en_d;
            vec_q   <= vec_d;
            data_q  <= data_d;
            addr_q  <= addr_d;
            num_q   <= num_d;
            int_q   <= int_d;
            state_q <= state_d;
        end
    end

    assign o_data     = data_q;
    assign o_int      = int_q;
    assign o_int_addr = addr_q;
    assign o_int_num  = num_q;

endmodule

// File: tb/tb_irq_scheduler.sv
// Self-checking bench for irq_scheduler: directed scenarios plus random traffic
// compared every cycle against a rule-level model.
module tb_irq_scheduler;

    localparam logic [15:0] BASE = 16'h0420;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        we = 1'b0;
    logic [15:0] addr = '0;
    logic [15:0] data = '0;
    logic [15:0] lines = '0;
    logic        ack = 1'b0;
    logic [15:0] o_data, o_int_addr;
    logic        o_int;
    logic [3:0]  o_int_num;

    int vectors = 0;
    int miscompares = 0;
    bit chk_en = 1'b0;

    irq_scheduler #(.BASE_ADDR(BASE), .VEC_SHIFT(2)) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_we       (we),
        .i_addr     (addr),
        .i_data     (data),
        .o_data     (o_data),
        .i_lines    (lines),
        .o_int      (o_int),
        .o_int_addr (o_int_addr),
        .o_int_num  (o_int_num),
        .i_ack      (ack)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: state 0=idle, 1=requesting, 2=in service.
    bit [15:0] m_pend, m_en, m_vec, m_prev, m_odata, m_addr;
    bit [3:0]  m_num;
    bit        m_int;
    int        m_state;

    always @(posedge clk) begin
        logic [15:0] off, rd, clr, edges;
        off = addr - BASE;
        if (rst) begin
            m_pend = 0; m_en = 0; m_vec = 0; m_odata = 0; m_addr = 0;
            m_num = 0; m_int = 0; m_state = 0;
        end else begin
            rd = 0;
            if (!we && off < 4) begin
                if (off == 0) rd = m_pend;
                else if (off == 1) rd = m_en;
                else if (off == 2) rd = m_vec;
                else rd = {m_state == 2, m_state == 1, 10'b0, m_num};
            end
            edges = lines & ~m_prev;
            clr = (we && off == 0) ? data : 16'h0;
            if (m_state == 0) begin
                if ((m_pend & m_en) != 0) begin
                    for (int i = 0; i < 16; i++) begin
                        if (m_pend[i] && m_en[i]) begin
                            m_num = 4'(i);
                            break;
                        end
                    end
                    m_int = 1;
                    m_addr = m_vec + 16'(int'(m_num) * 4);
                    m_state = 1;
                end
            end else if (m_state == 1) begin
                if (ack) begin
                    clr[m_num] = 1'b1;
                    m_int = 0;
                    m_state = 2;
                end else if (!(m_pend[m_num] && m_en[m_num])) begin
                    m_int = 0;
                    m_state = 0;
                end
            end else if (we && off == 3) begin
                m_state = 0;
            end
            m_pend = (m_pend & ~clr) | edges;
            if (we && off == 1) m_en = data;
            if (we && off == 2) m_vec = data;
            m_odata = rd;
        end
        m_prev = lines;
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("o_int", {15'b0, o_int}, {15'b0, m_int});
            chk("o_int_num", {12'b0, o_int_num}, {12'b0, m_num});
            chk("o_int_addr", o_int_addr, m_addr);
            chk("o_data", o_data, m_odata);
        end
    end

    task automatic bus_wr(input logic [1:0] o, input logic [15:0] d);
        @(negedge clk); we = 1; addr = BASE + 16'(o); data = d;
        @(negedge clk); we = 0; addr = 0; data = 0;
    endtask

    task automatic bus_rd(input logic [1:0] o, output logic [15:0] d);
        @(negedge clk); we = 0; addr = BASE + 16'(o);
        @(negedge clk); d = o_data; addr = 0;
    endtask

    task automatic pulse_ack();
        @(negedge clk); ack = 1;
        @(negedge clk); ack = 0;
    endtask

    initial begin
        logic [15:0] rd;
        repeat (2) @(negedge clk);
        chk_en = 1;
        rst = 0;
        chk("rst o_int", {15'b0, o_int}, 16'h0);
        chk("rst o_data", o_data, 16'h0);

        // 1: single line request with vector base
        bus_wr(1, 16'h0006);
        bus_wr(2, 16'h0100);
        @(negedge clk); lines = 16'h0004;
        @(negedge clk); lines = 16'h0000;
        @(negedge clk);
        chk("t1 o_int", {15'b0, o_int}, 16'h1);
        chk("t1 num", {12'b0, o_int_num}, 16'h2);
        chk("t1 addr", o_int_addr, 16'h0108);
        pulse_ack();
        bus_wr(3, 16'h0);

        // 2: two simultaneous lines, lowest index first
        bus_wr(1, 16'hFFFF);
        @(negedge clk); lines = 16'h0022;
        @(negedge clk);
        @(negedge clk);
        chk("t2 first num", {12'b0, o_int_num}, 16'h1);
        pulse_ack();
        bus_wr(3, 16'h0);
        @(negedge clk);
        chk("t2 second num", {12'b0, o_int_num}, 16'h5);
        chk("t2 second addr", o_int_addr, 16'h0114);
        pulse_ack();
        bus_rd(0, rd);
        chk("t2 pending", rd, 16'h0000);
        bus_wr(3, 16'h0);
        lines = 16'h0000;

        // 3: no preemption while requesting
        @(negedge clk); lines = 16'h0008;
        @(negedge clk);
        @(negedge clk);
        chk("t3 num", {12'b0, o_int_num}, 16'h3);
        lines = 16'h0009;
        @(negedge clk);
        chk("t3 still 3", {12'b0, o_int_num}, 16'h3);
        pulse_ack();
        bus_rd(3, rd);
        chk("t3 status", rd, 16'h8003);
        chk("t3 int low", {15'b0, o_int}, 16'h0);
        bus_wr(3, 16'h0);
        @(negedge clk);
        chk("t3 line0 num", {12'b0, o_int_num}, 16'h0);
        chk("t3 line0 int", {15'b0, o_int}, 16'h1);
        pulse_ack();
        bus_wr(3, 16'h0);
        lines = 16'h0000;

        // 4: withdraw by disabling, then re-enable
        @(negedge clk); lines = 16'h0010;
        @(negedge clk);
        @(negedge clk);
        chk("t4 num", {12'b0, o_int_num}, 16'h4);
        bus_wr(1, 16'hFFEF);
        @(negedge clk);
        chk("t4 withdrawn", {15'b0, o_int}, 16'h0);
        bus_rd(0, rd);
        chk("t4 pending", rd, 16'h0010);
        bus_rd(3, rd);
        chk("t4 status", rd, 16'h0004);
        bus_wr(1, 16'hFFFF);
        @(negedge clk);
        chk("t4 reassert", {15'b0, o_int}, 16'h1);
        pulse_ack();
        bus_wr(3, 16'h0);
        lines = 16'h0000;

        // 5: line held through reset, then set-wins-over-W1C
        @(negedge clk); lines = 16'h0080; rst = 1;
        @(negedge clk);
        @(negedge clk); rst = 0;
        @(negedge clk);
        bus_rd(0, rd);
        chk("t5 no pend", rd, 16'h0000);
        @(negedge clk); lines = 16'h0000;
        @(negedge clk); lines = 16'h0080;
        @(negedge clk);
        bus_rd(0, rd);
        chk("t5 pend7", rd, 16'h0080);
        @(negedge clk); lines = 16'h0000;
        @(negedge clk); lines = 16'h0080; we = 1; addr = BASE; data = 16'h0080;
        @(negedge clk); we = 0; addr = 0; data = 0;
        bus_rd(0, rd);
        chk("t5 set wins", rd, 16'h0080);

        // 6: reset during service, ack in idle
        bus_wr(1, 16'hFFFF);
        @(negedge clk);
        pulse_ack();
        bus_rd(3, rd);
        chk("t6 status svc", rd, 16'h8007);
        @(negedge clk); rst = 1;
        @(negedge clk); rst = 0;
        chk("t6 o_int", {15'b0, o_int}, 16'h0);
        for (int r = 0; r < 4; r++) begin
            bus_rd(2'(r), rd);
            chk("t6 reg zero", rd, 16'h0000);
        end
        pulse_ack();
        chk("t6 ack idle", {15'b0, o_int}, 16'h0);

        // Random traffic
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            lines = lines ^ (16'($urandom) & 16'($urandom) & 16'($urandom));
            ack   = ($urandom_range(0, 3) == 0);
            we    = ($urandom_range(0, 3) == 0);
            addr  = BASE - 16'd1 + 16'($urandom_range(0, 5));
            data  = 16'($urandom);
            if (we && addr == BASE && $urandom_range(0, 1) == 0) data = 16'($urandom) & 16'($urandom);
            rst   = ($urandom_range(0, 299) == 0);
        end
        @(negedge clk);
        we = 0; ack = 0; rst = 0; addr = 0;
        repeat (3) @(negedge clk);
        chk_en = 0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
